axi_dio_regs: RTL and testbench
===============================

AXI_DIO_REGS -- requirements
Module: axi_dio_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below (clock and reset first):
- GCLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- AWADDR  in  5  write address, byte-addressed, bits [1:0] ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data, full-word only (no strobes).
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  5  read address, bits [1:0] ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- start_out  out  1  one-cycle start pulse to the SPI master.
- spi_mode_out  out  2  CPOL/CPHA mode.
- sck_speed_out  out  2  SCK divider select.
- word_len_out  out  2  word length select.
- IFG_out  out  8  inter-frame gap.
- CS_SCK_out  out  8  CS-to-SCK delay.
- SCK_CS_out  out  8  SCK-to-CS delay.
- mosi_data_out  out  32  transmit word.
- busy_in  in  1  SPI master busy.
- miso_data_in  in  32  received word, valid when busy_in falls.

Function
REQ-002 Register map (AWADDR/ARADDR[4:2]):
- 0x00 CTRL RW: [1:0] spi_mode, [3:2] sck_speed, [5:4] word_len, [8] start (write-1, reads 0).
- 0x04 TIMING RW: [7:0] IFG, [15:8] CS_SCK, [23:16] SCK_CS.
- 0x08 TXDATA RW.
- 0x0C RXDATA RO.
- 0x10 STATUS: [0] busy_in (live), [1] done (sticky, W1C), [2] start_err (sticky, W1C).
- Unlisted bits read 0.
REQ-003 Write FSM SHALL have two states:
- W_IDLE: AWREADY=WREADY=1 only when AWVALID and WVALID are both 1; the handshake occurs that cycle.
- W_RESP: BVALID=1 held with a stable BRESP until BREADY, then return to W_IDLE.
- AW without W, or W without AW, SHALL wait with no handshake.
REQ-004 Read FSM SHALL have two states:
- R_IDLE: ARREADY=1; on handshake, RDATA/RRESP are registered and the FSM moves to R_DATA.
- R_DATA: RVALID=1, RDATA stable until RREADY, then return to R_IDLE.
REQ-005 Read and write FSMs SHALL operate independently and concurrently.
REQ-006 Register outputs SHALL update the cycle after the write handshake; BVALID SHALL rise that same cycle.
REQ-007 Writing CTRL with bit8=1 while busy_in=0 SHALL store the fields and pulse start_out for exactly one cycle, the cycle after the handshake.
REQ-008 Writes to CTRL, TIMING or TXDATA while busy_in=1 SHALL return SLVERR and leave registers unchanged; a CTRL write with bit8=1 in that case SHALL also set start_err.
REQ-009 Writes and reads to unmapped addresses, and writes to RXDATA, SHALL return SLVERR with no state change; unmapped reads SHALL return RDATA=0.
REQ-010 On a busy_in 1->0 transition (registered edge detect), RXDATA SHALL capture miso_data_in and done SHALL set.
REQ-011 If a sticky set and a W1C clear of the same bit occur in the same cycle, the set SHALL win.
REQ-012 STATUS reads SHALL return the busy_in value sampled in the handshake cycle.

Reset
REQ-013 While RST=0, all registers, outputs and RDATA SHALL be 0, start_out=0, BVALID=RVALID=0, AWREADY=WREADY=0, ARREADY=0, and both FSMs SHALL be in IDLE.
REQ-014 Reset asserted mid-transaction SHALL abort it; after release, AWREADY/WREADY/ARREADY behaviour SHALL resume from IDLE on the first clock edge.

Verification
REQ-015 Write TIMING=0x00_0A_05_03, then read it back -> OKAY; IFG_out=3, CS_SCK_out=5, SCK_CS_out=0x0A.
REQ-016 With busy_in=0, write CTRL=0x135 -> spi_mode_out=1, sck_speed_out=1, word_len_out=3; start_out high for exactly one cycle; CTRL reads back 0x035.
REQ-017 With busy_in=1, write TXDATA=0xDEADBEEF and CTRL=0x100 -> both SLVERR; mosi_data_out unchanged; no start_out pulse; STATUS=0x5.
REQ-018 Drive busy_in 1->0 with miso_data_in=0xA5A5_0F0F -> RXDATA reads 0xA5A50F0F; STATUS[1]=1; writing STATUS=0x2 clears it; a coincident fall with the clear leaves done=1.
REQ-019 Hold BREADY=0 for 5 cycles after a write and RREADY=0 during a concurrent read -> BVALID, BRESP, RVALID and RDATA stay stable; no new AW/AR handshake; read 0x14 -> SLVERR, RDATA=0.
REQ-020 Assert RST during W_RESP with BVALID=1 -> BVALID=0 immediately; all outputs 0; the next write completes normally.

Source files
------------

// File: rtl/axi_dio_regs.sv
// AXI4-Lite register bank for an SPI master: configuration, TX/RX words and
// sticky status. Write and read channels run independent two-state FSMs.
module axi_dio_regs (
    input  logic        GCLK,
    input  logic        RST,
    input  logic [4:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [4:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        start_out,
    output logic [1:0]  spi_mode_out,
    output logic [1:0]  sck_speed_out,
    output logic [1:0]  word_len_out,
    output logic [7:0]  IFG_out,
    output logic [7:0]  CS_SCK_out,
    output logic [7:0]  SCK_CS_out,
    output logic [31:0] mosi_data_out,
    input  logic        busy_in,
    input  logic [31:0] miso_data_in
);
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_TIMING = 3'd1;
    localparam logic [2:0] A_TXDATA = 3'd2;
    localparam logic [2:0] A_RXDATA = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic [5:0]  ctrl_q;
    logic [23:0] timing_q;
    logic [31:0] txdata_q, rxdata_q, rdata_q, rdata_d;
    logic [1:0]  bresp_q, rresp_q, rresp_d;
    logic        done_q, start_err_q, start_q, busy_prev_q;
    logic        wr_hs, rd_hs, busy_fall, cfg_sel, wr_err;
    logic        ctrl_we, timing_we, txdata_we, status_we, start_fire, start_err_set;
    logic [2:0]  w_idx, r_idx;
    logic        unused_addr_bits;

    assign w_idx            = AWADDR[4:2];
    assign r_idx            = ARADDR[4:2];
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
    assign wr_hs            = AWREADY;
    assign rd_hs            = ARVALID && ARREADY;
    assign busy_fall        = busy_prev_q && !busy_in;

    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (wr_hs) w_state_d = W_RESP;
            W_RESP:  if (BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (rd_hs) r_state_d = R_DATA;
            R_DATA:  if (RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W are accepted together only; RST gating keeps readies low in reset.
    always_comb begin
        AWREADY = RST && (w_state_q == W_IDLE) && AWVALID && WVALID;
        WREADY  = AWREADY;
        BVALID  = (w_state_q == W_RESP);
        ARREADY = RST && (r_state_q == R_IDLE);
        RVALID  = (r_state_q == R_DATA);
    end

    always_comb begin
        ctrl_we       = 1'b0;
        timing_we     = 1'b0;
        txdata_we     = 1'b0;
        status_we     = 1'b0;
        start_fire    = 1'b0;
        start_err_set = 1'b0;
        wr_err        = 1'b0;
        cfg_sel       = (w_idx == A_CTRL) || (w_idx == A_TIMING) || (w_idx == A_TXDATA);
        if (wr_hs) begin
            if (cfg_sel && busy_in) begin
                wr_err        = 1'b1;
                start_err_set = (w_idx == A_CTRL) && WDATA[8];
            end else begin
                case (w_idx)
                    A_CTRL:   begin ctrl_we = 1'b1; start_fire = WDATA[8]; end
                    A_TIMING: timing_we = 1'b1;
                    A_TXDATA: txdata_we = 1'b1;
                    A_STATUS: status_we = 1'b1;
                    default:  wr_err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = OKAY;
        case (r_idx)
            A_CTRL:   rdata_d = {26'b0, ctrl_q};
            A_TIMING: rdata_d = {8'b0, timing_q};
            A_TXDATA: rdata_d = txdata_q;
            A_RXDATA: rdata_d = rxdata_q;
            A_STATUS: rdata_d = {29'b0, start_err_q, done_q, busy_in};
            default:  rresp_d = SLVERR;
        endcase
    end

    always_ff @(posedge GCLK or negedge RST) begin
        if (!RST) begin
            ctrl_q      <= '0;
            timing_q    <= '0;
            txdata_q    <= '0;
            rxdata_q    <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            start_q     <= 1'b0;
            busy_prev_q <= 1'b0;
            bresp_q     <= OKAY;
            rresp_q     <= OKAY;
            rdata_q     <= '0;
        end else begin
            busy_prev_q <= busy_in;
            start_q     <= start_fire;
            if (ctrl_we)   ctrl_q   <= WDATA[5:0];
            if (timing_we) timing_q <= WDATA[23:0];
            if (txdata_we) txdata_q <= WDATA;
            if (busy_fall) rxdata_q <= miso_data_in;
            // A set in the same cycle as a W1C clear wins.
            done_q      <= busy_fall | (done_q & ~(status_we & WDATA[1]));
            start_err_q <= start_err_set | (start_err_q & ~(status_we & WDATA[2]));
            if (wr_hs) bresp_q <= wr_err ? SLVERR : OKAY;
            if (rd_hs) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    assign BRESP         = bresp_q;
    assign RDATA         = rdata_q;
    assign RRESP         = rresp_q;
    assign start_out     = start_q;
    assign spi_mode_out  = ctrl_q[1:0];
    assign sck_speed_out = ctrl_q[3:2];
    assign word_len_out  = ctrl_q[5:4];
    assign IFG_out       = timing_q[7:0];
    assign CS_SCK_out    = timing_q[15:8];
    assign SCK_CS_out    = timing_q[23:16];
    assign mosi_data_out = txdata_q;
endmodule

// File: tb/tb_axi_dio_regs.sv
// Scoreboard bench for axi_dio_regs: drivers push expected B/R responses from a
// register-map model, a monitor pops and compares at each response handshake.
module tb_axi_dio_regs;
  logic        GCLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  AWADDR = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0] WDATA = '0, miso_data_in = '0;
  logic        busy_in = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, start_out;
  logic [1:0]  BRESP, RRESP, spi_mode_out, sck_speed_out, word_len_out;
  logic [31:0] RDATA, mosi_data_out;
  logic [7:0]  IFG_out, CS_SCK_out, SCK_CS_out;

  axi_dio_regs dut (
    .GCLK(GCLK), .RST(RST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .start_out(start_out), .spi_mode_out(spi_mode_out), .sck_speed_out(sck_speed_out),
    .word_len_out(word_len_out), .IFG_out(IFG_out), .CS_SCK_out(CS_SCK_out),
    .SCK_CS_out(SCK_CS_out), .mosi_data_out(mosi_data_out),
    .busy_in(busy_in), .miso_data_in(miso_data_in)
  );

  // clock / reset
  always #5 GCLK = ~GCLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model of the register map
  logic [5:0]  ctrl_m;
  logic [23:0] timing_m;
  logic [31:0] tx_m, rx_m;
  logic        done_m, serr_m, busy_m;
  int          n_cmp = 0, n_err = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  task automatic model_reset();
    ctrl_m = '0; timing_m = '0; tx_m = '0; rx_m = '0;
    done_m = 1'b0; serr_m = 1'b0; busy_m = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one write to the model; returns response and whether start should pulse.
  task automatic model_write(input logic [4:0] a, input logic [31:0] d,
                             output logic [1:0] resp, output logic start_exp);
    int idx = int'(a >> 2);
    resp = 2'b00;
    start_exp = 1'b0;
    if (idx <= 2 && busy_in) begin
      resp = 2'b10;
      if (idx == 0 && d[8]) serr_m = 1'b1;
    end else if (idx == 0) begin
      ctrl_m = d[5:0];
      start_exp = d[8];
    end else if (idx == 1) timing_m = d[23:0];
    else if (idx == 2) tx_m = d;
    else if (idx == 4) begin
      if (d[1]) done_m = 1'b0;
      if (d[2]) serr_m = 1'b0;
    end else resp = 2'b10;
  endtask

  function automatic logic [33:0] model_read(input logic [4:0] a);
    int idx = int'(a >> 2);
    case (idx)
      0: return {2'b00, 26'd0, ctrl_m};
      1: return {2'b00, 8'd0, timing_m};
      2: return {2'b00, tx_m};
      3: return {2'b00, rx_m};
      4: return {2'b00, 29'd0, serr_m, done_m, busy_in};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic check_outputs();
    check("spi_mode", spi_mode_out, ctrl_m[1:0]);
    check("sck_speed", sck_speed_out, ctrl_m[3:2]);
    check("word_len", word_len_out, ctrl_m[5:4]);
    check("ifg", IFG_out, timing_m[7:0]);
    check("cs_sck", CS_SCK_out, timing_m[15:8]);
    check("sck_cs", SCK_CS_out, timing_m[23:16]);
    check("mosi", mosi_data_out, tx_m);
  endtask

  // monitor: compares each response at its handshake
  always begin
    @(negedge GCLK);
    #2;
    if (RST && BVALID && BREADY) begin
      if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", BRESP, exp_b_q.pop_front());
    end
    if (RST && RVALID && RREADY) begin
      if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
      else check("rresp_rdata", {RRESP, RDATA}, exp_r_q.pop_front());
    end
  end

  // driver tasks
  task automatic set_busy(input logic v, input logic [31:0] m);
    @(negedge GCLK);
    busy_in = v;
    if (!v) miso_data_in = m;
    @(posedge GCLK);
    #1;
    if (busy_m && !v) begin rx_m = m; done_m = 1'b1; end
    busy_m = v;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int bdly,
                          input bit fall_en, input logic [31:0] m);
    logic [1:0] er;
    logic       st;
    int         n = 0;
    @(negedge GCLK);
    AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    if (fall_en) begin busy_in = 1'b0; miso_data_in = m; end
    #1;
    while (!(AWREADY && WREADY) && n < 20) begin @(negedge GCLK); #1; n++; end
    if (n >= 20) begin
      check("aw_timeout", 0, 1);
      AWVALID = 1'b0; WVALID = 1'b0;
      return;
    end
    @(posedge GCLK);
    model_write(a, d, er, st);
    if (fall_en) begin rx_m = m; done_m = 1'b1; busy_m = 1'b0; end
    exp_b_q.push_back(er);
    #1;
    check("bvalid_rise", BVALID, 1);
    check("start_pulse", start_out, st);
    check_outputs();
    @(posedge GCLK);
    #1;
    check("start_one_cycle", start_out, 0);
    for (int i = 0; i < bdly; i++) begin
      @(negedge GCLK);
      #1;
      check("b_hold_valid", BVALID, 1);
      check("b_hold_resp", BRESP, er);
      check("b_hold_no_aw", AWREADY, 0);
    end
    @(negedge GCLK);
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(posedge GCLK);
    #1;
    check("b_done", BVALID, 0);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input int rdly);
    logic [33:0] e;
    int          n = 0;
    @(negedge GCLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    while (!ARREADY && n < 20) begin @(negedge GCLK); #1; n++; end
    if (n >= 20) begin
      check("ar_timeout", 0, 1);
      ARVALID = 1'b0;
      return;
    end
    @(posedge GCLK);
    e = model_read(a);
    exp_r_q.push_back(e);
    #1;
    check("rvalid_rise", RVALID, 1);
    for (int i = 0; i < rdly; i++) begin
      @(negedge GCLK);
      #1;
      check("r_hold_valid", RVALID, 1);
      check("r_hold_data", {RRESP, RDATA}, e);
      check("r_hold_no_ar", ARREADY, 0);
    end
    @(negedge GCLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    @(posedge GCLK);
    #1;
    check("r_done", RVALID, 0);
    RREADY = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_resp", {BRESP, RRESP}, 0);
    check("rst_start", start_out, 0);
    check_outputs();
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    model_reset();
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    repeat (3) @(posedge GCLK);
    #1;
    check_reset_state();
    @(negedge GCLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    RST = 1'b1;

    // timing register write and readback
    do_write(5'h04, 32'h000A0503, 0, 0, 0);
    check("ifg_3", IFG_out, 8'd3);
    check("cs_sck_5", CS_SCK_out, 8'd5);
    check("sck_cs_a", SCK_CS_out, 8'h0A);
    do_read(5'h04, 0);

    // control write with start
    do_write(5'h00, 32'h135, 1, 0, 0);
    check("ctrl_fields", {word_len_out, sck_speed_out, spi_mode_out}, 6'b11_01_01);
    do_read(5'h00, 0);
    check("ctrl_readback", RDATA, 32'h035);

    // writes while busy are rejected
    set_busy(1'b1, 0);
    do_write(5'h08, 32'hDEADBEEF, 0, 0, 0);
    do_write(5'h00, 32'h100, 0, 0, 0);
    do_read(5'h10, 0);
    check("status_busy_err", RDATA, 32'h5);

    // completion capture, W1C and coincident set/clear
    set_busy(1'b0, 32'hA5A50F0F);
    do_read(5'h0C, 0);
    check("rxdata", RDATA, 32'hA5A50F0F);
    do_read(5'h10, 0);
    do_write(5'h10, 32'h2, 0, 0, 0);
    do_read(5'h10, 0);
    set_busy(1'b1, 0);
    repeat (2) @(posedge GCLK);
    do_write(5'h10, 32'h2, 0, 1, 32'h1234_5678);
    do_read(5'h10, 0);
    check("done_set_wins", RDATA[1], 1);
    do_write(5'h10, 32'h4, 0, 0, 0);

    // backpressure on both channels at once, then error addresses
    fork
      do_write(5'h08, $urandom, 5, 0, 0);
      do_read(5'h04, 5);
    join
    do_read(5'h14, 2);
    do_write(5'h0C, $urandom, 0, 0, 0);
    do_write(5'h1C, $urandom, 0, 0, 0);
    do_read(5'h1D, 0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      if (sel < 2) set_busy(1'(($urandom_range(0, 1))), d);
      else if (sel < 6) do_write(a, d, $urandom_range(0, 2), 0, 0);
      else do_read(a, $urandom_range(0, 2));
    end
    set_busy(1'b0, 32'h0BAD_F00D);

    // reset during a pending write response
    do_write(5'h04, 32'h00FF_FFFF, 0, 0, 0);
    @(negedge GCLK);
    AWADDR = 5'h08; WDATA = 32'hCAFE_0001; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    @(posedge GCLK);
    #2;
    check("pre_rst_bvalid", BVALID, 1);
    RST = 1'b0;
    #1;
    model_reset();
    exp_b_q.delete();
    check_reset_state();
    @(negedge GCLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge GCLK);
    RST = 1'b1;
    do_write(5'h08, 32'h1357_9BDF, 0, 0, 0);
    do_read(5'h08, 1);

    repeat (4) @(posedge GCLK);
    check("b_queue_empty", exp_b_q.size(), 0);
    check("r_queue_empty", exp_r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
